// File: rtl/shake256_squeeze_arbiter.sv
// -----------------------------------------------------------------------------
// shake256_squeeze_arbiter
//
// Shares a single shake256_squeezeblocks core among NREQ requesters (for
// example the ExpandA / ExpandS / ExpandMask samplers of key generation).
// Requesters are granted round-robin. The granted requester's Keccak state and
// block count are latched and handed to the core. When the core finishes, its
// output and updated state are registered and returned to the owner with a
// one-cycle req_rts pulse. An illegal block count (0 or above MAX_BLOCKS) is
// answered with a one-cycle req_err pulse, and the core is not started.
//
// Ports
//   clock           in   1            rising-edge system clock
//   reset           in   1            asynchronous, active-low reset
//   req_rtr         in   NREQ         per-requester request (ready-to-receive)
//   req_state_in    in   NREQ*1600    packed states, slice i = [1600*i +: 1600]
//   req_nblocks     in   NREQ*64      packed block counts, slice i = [64*i +: 64]
//   req_rts         out  NREQ         one-cycle done pulse to the owner
//   req_err         out  NREQ         one-cycle illegal-count pulse to the owner
//   rsp_out         out  2176         squeezed data of the last completed job
//   rsp_state_out   out  1600         updated state of the last completed job
//   grant           out  NREQ         one-hot owner of the current transaction
//   busy            out  1            high whenever the FSM is not IDLE
//   core_rtr        out  1            one-cycle start pulse to the core
//   core_state_in   out  1600         latched state presented to the core
//   core_nblocks    out  64           latched block count presented to the core
//   core_out        in   2176         core squeeze output
//   core_state_out  in   1600         core updated state
//   core_rts        in   1            core done pulse
// -----------------------------------------------------------------------------
module shake256_squeeze_arbiter #(
  parameter int NREQ       = 2,
  parameter int MAX_BLOCKS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_rtr,
  input  logic [NREQ*1600-1:0] req_state_in,
  input  logic [NREQ*64-1:0]   req_nblocks,
  output logic [NREQ-1:0]      req_rts,
  output logic [NREQ-1:0]      req_err,
  output logic [2175:0]        rsp_out,
  output logic [1599:0]        rsp_state_out,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 core_rtr,
  output logic [1599:0]        core_state_in,
  output logic [63:0]          core_nblocks,
  input  logic [2175:0]        core_out,
  input  logic [1599:0]        core_state_out,
  input  logic                 core_rts
);

  // NREQ is at most 4, so a 2-bit index covers every requester.
  localparam int IDX_W = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [1599:0]      lat_state_q, lat_state_d;
  logic [63:0]        lat_nb_q, lat_nb_d;
  logic [2175:0]      rsp_out_q, rsp_out_d;
  logic [1599:0]      rsp_st_q, rsp_st_d;

  // ---------------------------------------------------------------------------
  // Round-robin selection.
  // Candidate gi is the requester gi places after the pointer, wrapped modulo
  // NREQ. The lowest-offset candidate with its rtr raised wins. req_rtr is
  // zero-padded to 4 bits so that a 2-bit index is always in range.
  // ---------------------------------------------------------------------------
  logic [3:0]       rtr_pad;
  logic [IDX_W-1:0] cand_idx [NREQ];
  logic [NREQ-1:0]  cand_hit;

  assign rtr_pad = 4'(req_rtr);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum          = {1'b0, ptr_q} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDX_W+1)'(NREQ)) ?
                            IDX_W'(sum - (IDX_W+1)'(NREQ)) : sum[IDX_W-1:0];
      assign cand_hit[gi] = rtr_pad[cand_idx[gi]];
    end
  endgenerate

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [3:0]       pick_oh4;
  logic [NREQ-1:0]  pick_oh;
  logic [1599:0]    pick_state;
  logic [63:0]      pick_nb;
  logic             pick_legal;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    // Walk from the far end so that the nearest hit to the pointer wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  assign pick_oh4 = 4'b0001 << pick_idx;
  assign pick_oh  = pick_oh4[NREQ-1:0];

  always_comb begin
    pick_state = '0;
    pick_nb    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_state = req_state_in[1600*i +: 1600];
        pick_nb    = req_nblocks[64*i +: 64];
      end
    end
  end

  // The block count is an unsigned 64-bit quantity. Only 1..MAX_BLOCKS is legal.
  assign pick_legal = (pick_nb != 64'd0) && (pick_nb <= 64'(MAX_BLOCKS));

  // The pointer moves to the requester after the one just served.
  logic [IDX_W-1:0] ptr_after_owner;
  assign ptr_after_owner = (owner_q == IDX_W'(NREQ - 1)) ? '0
                                                         : owner_q + IDX_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    lat_state_d = lat_state_q;
    lat_nb_d    = lat_nb_q;
    rsp_out_d   = rsp_out_q;
    rsp_st_d    = rsp_st_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d     = pick_oh;
          owner_d     = pick_idx;
          lat_state_d = pick_state;
          lat_nb_d    = pick_nb;
          state_d     = pick_legal ? S_ISSUE : S_ERR;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // No timeout: the core is trusted to answer eventually.
        if (core_rts) begin
          rsp_out_d = core_out;
          rsp_st_d  = core_state_out;
          state_d   = S_DONE;
        end
      end
      S_DONE, S_ERR: begin
        // New requests are not sampled here. They are seen in the next IDLE.
        ptr_d   = ptr_after_owner;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      lat_state_q <= '0;
      lat_nb_q    <= '0;
      rsp_out_q   <= '0;
      rsp_st_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      lat_state_q <= lat_state_d;
      lat_nb_q    <= lat_nb_d;
      rsp_out_q   <= rsp_out_d;
      rsp_st_q    <= rsp_st_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // The pulses are decoded from the state, so each one lasts exactly one cycle.
  // Reset forces IDLE and clears grant, which drops every pulse asynchronously.
  // ---------------------------------------------------------------------------
  assign grant         = grant_q;
  assign busy          = (state_q != S_IDLE);
  assign core_rtr      = (state_q == S_ISSUE);
  assign req_rts       = (state_q == S_DONE) ? grant_q : '0;
  assign req_err       = (state_q == S_ERR)  ? grant_q : '0;
  assign core_state_in = lat_state_q;
  assign core_nblocks  = lat_nb_q;
  assign rsp_out       = rsp_out_q;
  assign rsp_state_out = rsp_st_q;

endmodule

// File: tb/tb_shake256_squeeze_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for shake256_squeeze_arbiter.
// The reference model works at transaction level. It keeps a round-robin
// pointer, the last response, and the per-requester inputs. For each request it
// predicts the owner, legality, latched data and returned response. The bench
// itself plays the squeeze core and chooses the core's output data.
// -----------------------------------------------------------------------------
module tb_shake256_squeeze_arbiter;

  localparam int NREQ = 2;
  localparam int MAXB = 16;
  localparam int W    = 2176;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [NREQ-1:0]      req_rtr;
  logic [NREQ*1600-1:0] req_state_in;
  logic [NREQ*64-1:0]   req_nblocks;
  logic [NREQ-1:0]      req_rts;
  logic [NREQ-1:0]      req_err;
  logic [2175:0]        rsp_out;
  logic [1599:0]        rsp_state_out;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic                 core_rtr;
  logic [1599:0]        core_state_in;
  logic [63:0]          core_nblocks;
  logic [2175:0]        core_out;
  logic [1599:0]        core_state_out;
  logic                 core_rts;

  shake256_squeeze_arbiter #(.NREQ(NREQ), .MAX_BLOCKS(MAXB)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_rtr        (req_rtr),
    .req_state_in   (req_state_in),
    .req_nblocks    (req_nblocks),
    .req_rts        (req_rts),
    .req_err        (req_err),
    .rsp_out        (rsp_out),
    .rsp_state_out  (rsp_state_out),
    .grant          (grant),
    .busy           (busy),
    .core_rtr       (core_rtr),
    .core_state_in  (core_state_in),
    .core_nblocks   (core_nblocks),
    .core_out       (core_out),
    .core_state_out (core_state_out),
    .core_rts       (core_rts)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  int            ptr_m;
  logic [2175:0] rsp_m;
  logic [1599:0] rsp_st_m;
  logic [1599:0] st_m [NREQ];
  logic [63:0]   nb_m [NREQ];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (low 64 bits)", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2175:0] rand_bits();
    logic [2175:0] r;
    for (int w = 0; w < 68; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] rand_nb();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0)      return 64'd0;
    else if (sel == 1) return 64'(17 + $urandom_range(0, 100));
    else if (sel == 2) return {$urandom, $urandom};
    else               return 64'($urandom_range(1, MAXB));
  endfunction

  function automatic bit legal_nb(input logic [63:0] nb);
    return (nb != 64'd0) && (nb <= 64'(MAXB));
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_state_in[1600*i +: 1600] = st_m[i];
      req_nblocks[64*i +: 64]      = nb_m[i];
    end
  endtask

  task automatic model_reset();
    ptr_m    = 0;
    rsp_m    = '0;
    rsp_st_m = '0;
  endtask

  // Run one transaction from the current req_rtr pattern.
  //   drop_rtr: the owner drops rtr right after it is granted
  //   lat:      core cycles between the WAIT entry and core_rts (>= 1)
  //   keep_rtr: the owner keeps rtr high after completion (a new request)
  task automatic serve(input bit drop_rtr, input int lat, input bit keep_rtr);
    int              who;
    logic [NREQ-1:0] oh;
    bit              legal;
    bit              got;
    logic [1599:0]   st_lat;
    logic [63:0]     nb_lat;
    logic [2175:0]   d_out;
    logic [1599:0]   d_st;

    who = -1;
    for (int k = 0; k < NREQ; k++)
      if (who < 0 && req_rtr[(ptr_m + k) % NREQ]) who = (ptr_m + k) % NREQ;
    if (who < 0) begin
      chk("no_request", W'(req_rtr), W'(1));
      return;
    end
    oh = '0;
    oh[who] = 1'b1;
    st_lat = st_m[who];
    nb_lat = nb_m[who];
    legal  = legal_nb(nb_lat);

    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      if (grant != '0) got = 1'b1;
    end
    chk("grant_seen", W'(got), W'(1'b1));
    if (!got) return;

    chk("grant", W'(grant), W'(oh));
    chk("busy_on", W'(busy), W'(1'b1));
    chk("core_rtr_start", W'(core_rtr), W'(legal));
    chk("req_err", W'(req_err), legal ? W'(0) : W'(oh));
    chk("core_nblocks_lat", W'(core_nblocks), W'(nb_lat));
    chk("core_state_lat", W'(core_state_in), W'(st_lat));
    $display("txn owner=%0d nblocks=%0d legal=%0d lat=%0d", who, nb_lat, legal, lat);

    // The owner's inputs are latched, so they may change once it is granted.
    st_m[who] = rand_bits()[1599:0];
    nb_m[who] = 64'($urandom_range(1, MAXB));
    drive_reqs();
    if (drop_rtr) req_rtr[who] = 1'b0;

    if (!legal) begin
      if (!keep_rtr) req_rtr[who] = 1'b0;
      step();
      chk("err_busy_off", W'(busy), W'(1'b0));
      chk("err_grant_off", W'(grant), W'(0));
      chk("err_no_core", W'(core_rtr), W'(1'b0));
      chk("err_pulse_end", W'(req_err), W'(0));
      chk("err_rsp_kept", W'(rsp_out), W'(rsp_m));
      ptr_m = (who + 1) % NREQ;
      return;
    end

    core_rts = 1'b0;
    for (int c = 0; c < lat; c++) begin
      step();
      chk("wait_core_rtr", W'(core_rtr), W'(1'b0));
      chk("wait_state", W'(core_state_in), W'(st_lat));
      chk("wait_nblocks", W'(core_nblocks), W'(nb_lat));
      chk("wait_no_rts", W'(req_rts), W'(0));
    end

    d_out          = rand_bits();
    d_st           = rand_bits()[1599:0];
    core_out       = d_out;
    core_state_out = d_st;
    core_rts       = 1'b1;
    step();
    core_rts       = 1'b0;
    core_out       = rand_bits();
    core_state_out = rand_bits()[1599:0];
    rsp_m          = d_out;
    rsp_st_m       = d_st;
    chk("req_rts", W'(req_rts), W'(oh));
    chk("rsp_out", W'(rsp_out), W'(rsp_m));
    chk("rsp_state_out", W'(rsp_state_out), W'(rsp_st_m));
    if (!keep_rtr) req_rtr[who] = 1'b0;

    step();
    chk("rts_pulse_end", W'(req_rts), W'(0));
    chk("busy_off", W'(busy), W'(1'b0));
    chk("grant_off", W'(grant), W'(0));
    chk("rsp_hold", W'(rsp_out), W'(rsp_m));
    ptr_m = (who + 1) % NREQ;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    model_reset();
    chk("rst_busy", W'(busy), W'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_rtr        = '0;
    core_rts       = 1'b0;
    core_out       = '0;
    core_state_out = '0;
    for (int i = 0; i < NREQ; i++) begin
      st_m[i] = rand_bits()[1599:0];
      nb_m[i] = 64'd5;
    end
    drive_reqs();

    // Reset state.
    reset = 1'b0;
    repeat (3) step();
    chk("rst_grant", W'(grant), W'(0));
    chk("rst_busy", W'(busy), W'(1'b0));
    chk("rst_core_rtr", W'(core_rtr), W'(1'b0));
    chk("rst_req_rts", W'(req_rts), W'(0));
    chk("rst_req_err", W'(req_err), W'(0));
    chk("rst_rsp_out", W'(rsp_out), W'(0));
    chk("rst_core_nb", W'(core_nblocks), W'(0));
    reset = 1'b1;
    model_reset();

    // Single request with a 10-cycle core.
    req_rtr = 2'b01;
    serve(1'b0, 10, 1'b0);

    // Round-robin with both requesters always requesting.
    do_reset();
    for (int i = 0; i < NREQ; i++) nb_m[i] = 64'($urandom_range(1, MAXB));
    drive_reqs();
    req_rtr = 2'b11;
    repeat (4) serve(1'b0, $urandom_range(1, 6), 1'b1);
    req_rtr = '0;

    // Illegal counts.
    nb_m[0] = 64'd0;  drive_reqs(); req_rtr = 2'b01; serve(1'b0, 3, 1'b0);
    nb_m[0] = 64'd17; drive_reqs(); req_rtr = 2'b01; serve(1'b0, 3, 1'b0);
    nb_m[1] = 64'hFFFF_FFFF_FFFF_FFFF; drive_reqs(); req_rtr = 2'b10; serve(1'b0, 3, 1'b0);

    // Maximum count.
    nb_m[0] = 64'd16; drive_reqs(); req_rtr = 2'b01; serve(1'b0, 4, 1'b0);

    // A spurious core_rts while IDLE is ignored.
    req_rtr  = '0;
    core_rts = 1'b1;
    core_out = rand_bits();
    repeat (3) begin
      step();
      chk("spur_busy", W'(busy), W'(1'b0));
      chk("spur_rts", W'(req_rts), W'(0));
      chk("spur_rsp", W'(rsp_out), W'(rsp_m));
    end
    core_rts = 1'b0;

    // rtr dropped during the transaction: it still completes.
    nb_m[1] = 64'd9; drive_reqs(); req_rtr = 2'b10; serve(1'b1, 4, 1'b0);

    // Random traffic.
    repeat (24) begin
      for (int i = 0; i < NREQ; i++) begin
        st_m[i] = rand_bits()[1599:0];
        nb_m[i] = rand_nb();
      end
      drive_reqs();
      req_rtr = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      serve(1'($urandom_range(0, 1)), $urandom_range(1, 8), 1'b0);
      req_rtr = '0;
    end

    // Reset in WAIT. First move the pointer to 1 with a requester-0 job.
    nb_m[0] = 64'd3; drive_reqs(); req_rtr = 2'b01; serve(1'b0, 2, 1'b0);
    nb_m[1] = 64'd7; drive_reqs(); req_rtr = 2'b10;
    begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        step();
        if (grant != '0) got = 1'b1;
      end
      chk("rstw_grant", W'(grant), W'(2'b10));
    end
    repeat (3) step();
    #2;
    reset = 1'b0;
    #1;
    chk("rstw_grant0", W'(grant), W'(0));
    chk("rstw_busy0", W'(busy), W'(1'b0));
    chk("rstw_core_rtr0", W'(core_rtr), W'(1'b0));
    chk("rstw_rts0", W'(req_rts), W'(0));
    chk("rstw_err0", W'(req_err), W'(0));
    chk("rstw_rsp0", W'(rsp_out), W'(0));
    chk("rstw_rspst0", W'(rsp_state_out), W'(0));
    chk("rstw_cstate0", W'(core_state_in), W'(0));
    chk("rstw_cnb0", W'(core_nblocks), W'(0));
    req_rtr = '0;
    model_reset();
    step();
    reset = 1'b1;
    // A late answer from the abandoned job must not produce an rts.
    core_rts = 1'b1;
    step();
    core_rts = 1'b0;
    chk("rstw_late_rts", W'(req_rts), W'(0));
    repeat (3) begin
      step();
      chk("rstw_no_rts", W'(req_rts), W'(0));
      chk("rstw_idle", W'(busy), W'(1'b0));
    end
    // The pointer restarts at 0, so requester 0 wins the tie.
    nb_m[0] = 64'd2; nb_m[1] = 64'd4; drive_reqs();
    req_rtr = 2'b11;
    serve(1'b0, 2, 1'b0);
    req_rtr = '0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
